// File: rtl/demux_slot_sched_pkg.sv
// Shared constants and state encoding for the 16-channel time-slot scheduler.
package demux_slot_sched_pkg;

  localparam int NCH   = 16;
  localparam int SEL_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEEK = 2'd1,
    XFER = 2'd2
  } state_t;

endpackage

// File: rtl/demux_slot_sched_rr_next_chan.sv
// Rotating first-set finder: returns the first set mask bit after i_start,
// wrapping 15 -> 0, with i_start itself examined last.
module rr_next_chan
  import demux_slot_sched_pkg::*;
(
  input  logic [NCH-1:0]   i_mask,
  input  logic [SEL_W-1:0] i_start,
  output logic [SEL_W-1:0] o_idx,
  output logic             o_found
);

  always_comb begin
    logic [SEL_W-1:0] cand;
    o_found = 1'b0;
    o_idx   = i_start;
    cand    = i_start;
    // Offset NCH truncates to 0, so the starting channel is the final candidate.
    for (int k = 1; k <= NCH; k++) begin
      cand = i_start + SEL_W'(k);
      if (!o_found && i_mask[cand]) begin
        o_found = 1'b1;
        o_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/demux_slot_sched.sv
// Round-robin time-slot scheduler driving the select and valid/ready gating
// of a 1-to-16 stream demultiplexer, BURST beats per channel slot.
module demux_slot_sched
  import demux_slot_sched_pkg::*;
#(
  parameter int DW    = 8,
  parameter int BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic [NCH-1:0]   i_ch_mask,
  input  logic             i_in_valid,
  input  logic [DW-1:0]    i_in_data,
  output logic             o_in_ready,
  output logic [NCH-1:0]   o_out_valid,
  output logic [DW-1:0]    o_out_data,
  input  logic [NCH-1:0]   i_out_ready,
  output logic [SEL_W-1:0] o_sel,
  output logic             o_slot_done,
  output logic             o_busy
);

  localparam int            CW   = $clog2(BURST + 1);
  localparam logic [CW-1:0] LAST = CW'(BURST - 1);

  state_t           r_state;
  logic [SEL_W-1:0] r_sel;
  logic [CW-1:0]    r_beatCnt;
  logic             r_slotDone;

  logic [SEL_W-1:0] w_nextIdx;
  logic             w_found;
  logic             w_live;
  logic             w_fire;

  rr_next_chan u_rr (
    .i_mask  (i_ch_mask),
    .i_start (r_sel),
    .o_idx   (w_nextIdx),
    .o_found (w_found)
  );

  // A disable or a cleared own-mask bit kills the transfer in the same cycle it is seen.
  assign w_live = (r_state == XFER) && i_en && i_ch_mask[r_sel];
  assign w_fire = w_live && i_in_valid && i_out_ready[r_sel];

  assign o_in_ready  = w_live && i_out_ready[r_sel];
  assign o_out_data  = i_in_data;
  assign o_sel       = r_sel;
  assign o_slot_done = r_slotDone;
  assign o_busy      = (r_state != IDLE);

  always_comb begin
    o_out_valid = '0;
    if (w_live && i_in_valid) o_out_valid[r_sel] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_sel      <= 4'hF;
      r_beatCnt  <= '0;
      r_slotDone <= 1'b0;
    end else begin
      r_slotDone <= 1'b0;
      case (r_state)
        IDLE: begin
          r_beatCnt <= '0;
          if (i_en && |i_ch_mask) r_state <= SEEK;
        end
        SEEK: begin
          r_beatCnt <= '0;
          if (w_found) begin
            r_sel   <= w_nextIdx;
            r_state <= XFER;
          end else begin
            r_state <= IDLE;
          end
        end
        XFER: begin
          if (!i_en) begin
            r_beatCnt <= '0;
            r_state   <= IDLE;
          end else if (!i_ch_mask[r_sel]) begin
            r_beatCnt <= '0;
            r_state   <= SEEK;
          end else if (w_fire) begin
            if (r_beatCnt == LAST) begin
              r_beatCnt  <= '0;
              r_slotDone <= 1'b1;
              r_state    <= SEEK;
            end else begin
              r_beatCnt <= r_beatCnt + CW'(1);
            end
          end
        end
        default: begin
          r_beatCnt <= '0;
          r_state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_demux_slot_sched.sv
// Self-checking bench for demux_slot_sched: directed vector table, corner
// sequences and a long randomized run against a slot-level reference model.
module tb_demux_slot_sched;

  localparam int DW    = 8;
  localparam int BURST = 4;

  logic          clk;
  logic          rst_n;
  logic          en;
  logic [15:0]   chMask;
  logic          inValid;
  logic [DW-1:0] inData;
  logic          inReady;
  logic [15:0]   outValid;
  logic [DW-1:0] outData;
  logic [15:0]   outReady;
  logic [3:0]    sel;
  logic          slotDone;
  logic          busy;

  int vectors;
  int miscompares;

  // Reference model: phase 0 = no slot, 1 = gap cycle, 2 = slot granted.
  int mPhase;
  int mSel;
  int mBeats;
  bit mDone;

  typedef struct {
    logic        en;
    logic [15:0] mask;
    logic        inValid;
    logic [15:0] outReady;
    logic [3:0]  expSel;
    logic        expBusy;
    logic        expDone;
    logic [15:0] expOv;
    logic        expIr;
  } vec_t;

  vec_t tbl[13];

  demux_slot_sched #(.DW(DW), .BURST(BURST)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_en        (en),
    .i_ch_mask   (chMask),
    .i_in_valid  (inValid),
    .i_in_data   (inData),
    .o_in_ready  (inReady),
    .o_out_valid (outValid),
    .o_out_data  (outData),
    .i_out_ready (outReady),
    .o_sel       (sel),
    .o_slot_done (slotDone),
    .o_busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int nextChan(input logic [15:0] mask, input int cur);
    for (int k = 1; k <= 16; k++) begin
      if (mask[(cur + k) % 16]) return (cur + k) % 16;
    end
    return cur;
  endfunction

  task automatic modelReset();
    mPhase = 0;
    mSel   = 15;
    mBeats = 0;
    mDone  = 0;
  endtask

  task automatic applyStimulus(input logic e, input logic [15:0] m, input logic v,
                               input logic [15:0] r, input logic [DW-1:0] d, input logic rn);
    @(negedge clk);
    en       = e;
    chMask   = m;
    inValid  = v;
    outReady = r;
    inData   = d;
    rst_n    = rn;
    #1;
    if (!rn) modelReset();
  endtask

  task automatic checkOutput(input string tag);
    bit          live;
    logic [15:0] expOv;
    live  = (mPhase == 2) && en && chMask[mSel];
    expOv = (live && inValid) ? (16'd1 << mSel) : 16'd0;
    check({tag, ".sel"},      32'(sel),      32'(mSel));
    check({tag, ".busy"},     32'(busy),     32'(mPhase != 0));
    check({tag, ".slotDone"}, 32'(slotDone), 32'(mDone));
    check({tag, ".outValid"}, 32'(outValid), 32'(expOv));
    check({tag, ".inReady"},  32'(inReady),  32'(live && outReady[mSel]));
    check({tag, ".outData"},  32'(outData),  32'(inData));
  endtask

  task automatic modelAdvance();
    int nPhase, nSel, nBeats;
    bit nDone, fire;
    nPhase = mPhase;
    nSel   = mSel;
    nBeats = mBeats;
    nDone  = 0;
    fire   = (mPhase == 2) && en && chMask[mSel] && inValid && outReady[mSel];
    if (!rst_n) begin
      nPhase = 0; nSel = 15; nBeats = 0;
    end else if (mPhase == 0) begin
      if (en && chMask != 0) nPhase = 1;
    end else if (mPhase == 1) begin
      if (chMask == 0) nPhase = 0;
      else begin
        nSel = nextChan(chMask, mSel); nBeats = 0; nPhase = 2;
      end
    end else begin
      if (!en) begin
        nPhase = 0; nBeats = 0;
      end else if (!chMask[mSel]) begin
        nPhase = 1; nBeats = 0;
      end else if (fire) begin
        nBeats = mBeats + 1;
        if (nBeats == BURST) begin
          nBeats = 0; nPhase = 1; nDone = 1;
        end
      end
    end
    @(posedge clk);
    mPhase = nPhase;
    mSel   = nSel;
    mBeats = nBeats;
    mDone  = nDone;
  endtask

  task automatic cycle(input logic e, input logic [15:0] m, input logic v,
                       input logic [15:0] r, input string tag);
    applyStimulus(e, m, v, r, 8'($urandom), 1'b1);
    checkOutput(tag);
    modelAdvance();
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 16'h0, 1'b0, 16'h0, 8'h00, 1'b0);
    checkOutput("reset");
    modelAdvance();
  endtask

  initial begin
    int cnt;
    bit flag;
    int prevSel;
    logic [15:0] rMask;
    vectors     = 0;
    miscompares = 0;
    en = 0; chMask = 0; inValid = 0; outReady = 0; inData = 0; rst_n = 0;
    modelReset();

    // All channels, all ready: first two slots cycle by cycle.
    tbl[0]  = '{1'b1, 16'hFFFF, 1'b1, 16'hFFFF, 4'hF, 1'b0, 1'b0, 16'h0000, 1'b0};
    tbl[1]  = '{1'b1, 16'hFFFF, 1'b1, 16'hFFFF, 4'hF, 1'b1, 1'b0, 16'h0000, 1'b0};
    tbl[2]  = '{1'b1, 16'hFFFF, 1'b1, 16'hFFFF, 4'h0, 1'b1, 1'b0, 16'h0001, 1'b1};
    tbl[3]  = '{1'b1, 16'hFFFF, 1'b1, 16'hFFFF, 4'h0, 1'b1, 1'b0, 16'h0001, 1'b1};
    tbl[4]  = '{1'b1, 16'hFFFF, 1'b1, 16'hFFFF, 4'h0, 1'b1, 1'b0, 16'h0001, 1'b1};
    tbl[5]  = '{1'b1, 16'hFFFF, 1'b1, 16'hFFFF, 4'h0, 1'b1, 1'b0, 16'h0001, 1'b1};
    tbl[6]  = '{1'b1, 16'hFFFF, 1'b1, 16'hFFFF, 4'h0, 1'b1, 1'b1, 16'h0000, 1'b0};
    tbl[7]  = '{1'b1, 16'hFFFF, 1'b1, 16'hFFFF, 4'h1, 1'b1, 1'b0, 16'h0002, 1'b1};
    tbl[8]  = '{1'b1, 16'hFFFF, 1'b1, 16'hFFFF, 4'h1, 1'b1, 1'b0, 16'h0002, 1'b1};
    tbl[9]  = '{1'b1, 16'hFFFF, 1'b1, 16'hFFFF, 4'h1, 1'b1, 1'b0, 16'h0002, 1'b1};
    tbl[10] = '{1'b1, 16'hFFFF, 1'b1, 16'hFFFF, 4'h1, 1'b1, 1'b0, 16'h0002, 1'b1};
    tbl[11] = '{1'b1, 16'hFFFF, 1'b1, 16'hFFFF, 4'h1, 1'b1, 1'b1, 16'h0000, 1'b0};
    tbl[12] = '{1'b1, 16'hFFFF, 1'b1, 16'hFFFF, 4'h2, 1'b1, 1'b0, 16'h0004, 1'b1};

    $display("[TB] reset and directed table");
    doReset();
    doReset();
    for (int i = 0; i < 13; i++) begin
      applyStimulus(tbl[i].en, tbl[i].mask, tbl[i].inValid, tbl[i].outReady, 8'(i * 7 + 3), 1'b1);
      check($sformatf("tbl%0d.sel", i),      32'(sel),      32'(tbl[i].expSel));
      check($sformatf("tbl%0d.busy", i),     32'(busy),     32'(tbl[i].expBusy));
      check($sformatf("tbl%0d.slotDone", i), 32'(slotDone), 32'(tbl[i].expDone));
      check($sformatf("tbl%0d.outValid", i), 32'(outValid), 32'(tbl[i].expOv));
      check($sformatf("tbl%0d.inReady", i),  32'(inReady),  32'(tbl[i].expIr));
      checkOutput("tblModel");
      modelAdvance();
    end

    // Continue the full-mask run: 16 more slots, including the 15 -> 0 wrap.
    cnt = 0; flag = 0; prevSel = 2;
    for (int i = 0; i < 80; i++) begin
      applyStimulus(1'b1, 16'hFFFF, 1'b1, 16'hFFFF, 8'($urandom), 1'b1);
      checkOutput("full");
      if (slotDone === 1'b1) cnt++;
      if (prevSel == 15 && sel == 4'h0) flag = 1;
      prevSel = int'(sel);
      modelAdvance();
    end
    check("full.slotDoneCount", 32'(cnt), 32'd16);
    check("full.wrapSeen", 32'(flag), 32'd1);

    $display("[TB] two-channel mask 8001");
    doReset();
    flag = 0; cnt = 0;
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b1, 16'h8001, 1'b1, 16'hFFFF, 8'($urandom), 1'b1);
      checkOutput("m8001");
      if ((outValid & 16'h7FFE) != 0) flag = 1;
      if (outValid == 16'h8000) cnt++;
      modelAdvance();
    end
    check("m8001.midChannelsQuiet", 32'(flag), 32'd0);
    check("m8001.ch15Beats", 32'(cnt != 0), 32'd1);

    $display("[TB] own-mask abort on channel 3");
    doReset();
    for (int i = 0; i < 4; i++) cycle(1'b1, 16'h0018, 1'b1, 16'hFFFF, "abortPre");
    applyStimulus(1'b1, 16'h0010, 1'b1, 16'hFFFF, 8'h5A, 1'b1);
    check("abort.selAt3", 32'(sel), 32'd3);
    check("abort.outValidKilled", 32'(outValid), 32'd0);
    check("abort.inReadyKilled", 32'(inReady), 32'd0);
    checkOutput("abort");
    modelAdvance();
    applyStimulus(1'b1, 16'h0010, 1'b1, 16'hFFFF, 8'h11, 1'b1);
    check("abort.gapBusy", 32'(busy), 32'd1);
    check("abort.noSlotDone", 32'(slotDone), 32'd0);
    checkOutput("abortGap");
    modelAdvance();
    applyStimulus(1'b1, 16'h0010, 1'b1, 16'hFFFF, 8'h22, 1'b1);
    check("abort.nextSel", 32'(sel), 32'd4);
    check("abort.nextValid", 32'(outValid), 32'h0010);
    checkOutput("abortNext");
    modelAdvance();

    $display("[TB] downstream stall mid-burst");
    doReset();
    for (int i = 0; i < 4; i++) cycle(1'b1, 16'hFFFF, 1'b1, 16'hFFFF, "stallPre");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 16'hFFFF, 1'b1, 16'hFFFE, 8'($urandom), 1'b1);
      check("stall.inReadyLow", 32'(inReady), 32'd0);
      check("stall.selHeld", 32'(sel), 32'd0);
      checkOutput("stall");
      modelAdvance();
    end
    for (int i = 0; i < 2; i++) cycle(1'b1, 16'hFFFF, 1'b1, 16'hFFFF, "stallResume");
    applyStimulus(1'b1, 16'hFFFF, 1'b1, 16'hFFFF, 8'h00, 1'b1);
    check("stall.slotDoneAfterResume", 32'(slotDone), 32'd1);
    checkOutput("stallDone");
    modelAdvance();

    $display("[TB] single channel 2 and mask drop during gap");
    doReset();
    for (int i = 0; i < 7; i++) cycle(1'b1, 16'h0004, 1'b1, 16'hFFFF, "single");
    applyStimulus(1'b1, 16'h0004, 1'b1, 16'hFFFF, 8'h33, 1'b1);
    check("single.reselect", 32'(sel), 32'd2);
    check("single.valid", 32'(outValid), 32'h0004);
    checkOutput("singleRe");
    modelAdvance();
    for (int i = 0; i < 3; i++) cycle(1'b1, 16'h0004, 1'b1, 16'hFFFF, "single2");
    applyStimulus(1'b1, 16'h0000, 1'b1, 16'hFFFF, 8'h44, 1'b1);
    check("single.gapDone", 32'(slotDone), 32'd1);
    checkOutput("singleGap");
    modelAdvance();
    applyStimulus(1'b1, 16'h0000, 1'b1, 16'hFFFF, 8'h55, 1'b1);
    check("single.idleBusy", 32'(busy), 32'd0);
    check("single.selKept", 32'(sel), 32'd2);
    checkOutput("singleIdle");
    modelAdvance();

    $display("[TB] async reset mid-burst on channel 7");
    doReset();
    for (int i = 0; i < 4; i++) cycle(1'b1, 16'h0080, 1'b1, 16'hFFFF, "rstPre");
    applyStimulus(1'b1, 16'h0080, 1'b1, 16'hFFFF, 8'h66, 1'b1);
    check("rst.preValid", 32'(outValid), 32'h0080);
    checkOutput("rstBeat2");
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    check("rst.sel", 32'(sel), 32'hF);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.outValid", 32'(outValid), 32'd0);
    check("rst.inReady", 32'(inReady), 32'd0);
    check("rst.slotDone", 32'(slotDone), 32'd0);
    modelAdvance();
    for (int i = 0; i < 2; i++) cycle(1'b1, 16'hFFFF, 1'b1, 16'hFFFF, "rstPost");
    applyStimulus(1'b1, 16'hFFFF, 1'b1, 16'hFFFF, 8'h77, 1'b1);
    check("rst.firstSlotCh0", 32'(sel), 32'd0);
    checkOutput("rstFirst");
    modelAdvance();

    $display("[TB] randomized run");
    doReset();
    rMask = 16'hFFFF;
    for (int i = 0; i < 3000; i++) begin
      logic e, v, rn;
      logic [15:0] r;
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 3))
          0: rMask = 16'($urandom);
          1: rMask = 16'd1 << $urandom_range(0, 15);
          2: rMask = 16'h0000;
          default: rMask = 16'($urandom) & 16'($urandom);
        endcase
      end
      e  = ($urandom_range(0, 15) != 0);
      v  = ($urandom_range(0, 3) != 0);
      r  = 16'($urandom) | 16'($urandom);
      rn = ($urandom_range(0, 299) != 0);
      applyStimulus(e, rMask, v, r, 8'($urandom), rn);
      checkOutput("rand");
      modelAdvance();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
